// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit for a multicycle RV32I core. It decodes the instruction
// register and steps the shared datapath through fetch, decode, execute,
// memory and writeback cycles. Supported: lw, sw, R-type, I-type ALU, the six
// branches, jal, jalr, lui and auipc.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   instr[31:0]    in   instruction register contents
//   zero           in   ALU zero flag (combinational, current cycle)
//   we_pc          out  PC register enable
//   we_ir          out  instruction / old-PC register enable
//   we_rf          out  register file write enable
//   we_mem         out  data memory write strobe
//   sel_mem_addr   out  memory address: 0 = pc, 1 = result
//   sel_alu_src_a  out  0 = pc, 1 = old_pc, 2 = A (rs1)
//   sel_alu_src_b  out  0 = B (rs2), 1 = imm_ext, 2 = constant 4
//   sel_result     out  0 = ALUOut, 1 = memory data register, 2 = ALU result
//   sel_ext        out  000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control    out  ALU operation code
//   illegal        out  one-cycle pulse on unsupported opcode / branch funct3
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        we_pc,
    output logic        we_ir,
    output logic        we_rf,
    output logic        we_mem,
    output logic        sel_mem_addr,
    output logic [1:0]  sel_alu_src_a,
    output logic [1:0]  sel_alu_src_b,
    output logic [1:0]  sel_result,
    output logic [2:0]  sel_ext,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI,
        S_AUIPC
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_J = 3'b011;
    localparam logic [2:0] EXT_U = 3'b100;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_COPY_B = 4'b1111;

    state_t state, state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    // Register fields and immediates are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Shared funct3 decode for register and immediate ALU ops; alt selects
    // SUB for 000 and SRA for 101.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Enables before reset gating.
    logic pc_en, ir_en, rf_en, mem_en, ill_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_en         = 1'b0;
        ir_en         = 1'b0;
        rf_en         = 1'b0;
        mem_en        = 1'b0;
        ill_raw       = 1'b0;
        sel_mem_addr  = 1'b0;
        sel_alu_src_a = 2'd0;
        sel_alu_src_b = 2'd0;
        sel_result    = 2'd0;
        sel_ext       = EXT_I;
        alu_control   = ALU_ADD;

        case (state)
            S_FETCH: begin
                ir_en         = 1'b1;
                pc_en         = 1'b1;
                sel_alu_src_b = 2'd2;
                sel_result    = 2'd2;
                state_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <- old_pc + imm: jump target for jal, branch target otherwise.
                sel_alu_src_a = 2'd1;
                sel_alu_src_b = 2'd1;
                sel_ext       = (opcode == OP_JAL) ? EXT_J : EXT_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
                        ill_raw    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                sel_alu_src_a = 2'd2;
                sel_alu_src_b = 2'd1;
                // opcode bit 5 distinguishes store from load
                sel_ext       = opcode[5] ? EXT_S : EXT_I;
                state_next    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                sel_mem_addr = 1'b1;
                state_next   = S_MEMWB;
            end
            S_MEMWB: begin
                sel_result = 2'd1;
                rf_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                sel_mem_addr = 1'b1;
                mem_en       = 1'b1;
                state_next   = S_FETCH;
            end
            S_EXECR: begin
                sel_alu_src_a = 2'd2;
                alu_control   = alu_decode(funct3, funct7b5);
                state_next    = S_ALUWB;
            end
            S_EXECI: begin
                // funct7[5] in I-type is immediate data except for shifts.
                sel_alu_src_a = 2'd2;
                sel_alu_src_b = 2'd1;
                alu_control   = alu_decode(funct3, (funct3 == 3'b101) && funct7b5);
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                rf_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // The only Mealy output: PC load follows the live zero flag.
                sel_alu_src_a = 2'd2;
                state_next    = S_FETCH;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  pc_en = zero;  end
                    3'b001: begin alu_control = ALU_SUB;  pc_en = !zero; end
                    3'b100: begin alu_control = ALU_SLT;  pc_en = !zero; end
                    3'b101: begin alu_control = ALU_SLT;  pc_en = zero;  end
                    3'b110: begin alu_control = ALU_SLTU; pc_en = !zero; end
                    3'b111: begin alu_control = ALU_SLTU; pc_en = zero;  end
                    default: ill_raw = 1'b1;
                endcase
            end
            S_JALR: begin
                // Target bit 0 is deliberately left as computed.
                sel_alu_src_a = 2'd2;
                sel_alu_src_b = 2'd1;
                state_next    = S_JAL;
            end
            S_JAL: begin
                // PC <- ALUOut (target) while ALU forms the link old_pc + 4.
                sel_alu_src_a = 2'd1;
                sel_alu_src_b = 2'd2;
                pc_en         = 1'b1;
                state_next    = S_ALUWB;
            end
            S_LUI: begin
                sel_alu_src_b = 2'd1;
                sel_ext       = EXT_U;
                alu_control   = ALU_COPY_B;
                state_next    = S_ALUWB;
            end
            S_AUIPC: begin
                sel_alu_src_a = 2'd1;
                sel_alu_src_b = 2'd1;
                sel_ext       = EXT_U;
                state_next    = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // State is already FETCH during reset; only the strobes need gating.
    assign we_pc   = pc_en   & rst;
    assign we_ir   = ir_en   & rst;
    assign we_rf   = rf_en   & rst;
    assign we_mem  = mem_en  & rst;
    assign illegal = ill_raw & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. All outputs are packed into one
// 19-bit vector {we_pc, we_ir, we_rf, we_mem, sel_mem_addr, src_a, src_b,
// sel_result, sel_ext, alu_control, illegal} and compared cycle by cycle
// against hand-written expected vectors.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        we_pc, we_ir, we_rf, we_mem, sel_mem_addr, illegal;
    logic [1:0]  sel_alu_src_a, sel_alu_src_b, sel_result;
    logic [2:0]  sel_ext;
    logic [3:0]  alu_control;

    int vectors;
    int miscompares;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .zero          (zero),
        .we_pc         (we_pc),
        .we_ir         (we_ir),
        .we_rf         (we_rf),
        .we_mem        (we_mem),
        .sel_mem_addr  (sel_mem_addr),
        .sel_alu_src_a (sel_alu_src_a),
        .sel_alu_src_b (sel_alu_src_b),
        .sel_result    (sel_result),
        .sel_ext       (sel_ext),
        .alu_control   (alu_control),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {we_pc, we_ir, we_rf, we_mem, sel_mem_addr, sel_alu_src_a,
                  sel_alu_src_b, sel_result, sel_ext, alu_control, illegal};

    //                              pc    ir    rf    mem   ma    srcA  srcB  res   ext     alu      ill
    localparam logic [18:0] V_RST    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_FETCH  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_DEC_B  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'b010, 4'b0000, 1'b0};
    localparam logic [18:0] V_DEC_J  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'b011, 4'b0000, 1'b0};
    localparam logic [18:0] V_DEC_IL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'b010, 4'b0000, 1'b1};
    localparam logic [18:0] V_EXECI  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_SUB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 1'b0};
    localparam logic [18:0] V_SRA    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b1001, 1'b0};
    localparam logic [18:0] V_ALUWB  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_BEQ_T  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 1'b0};
    localparam logic [18:0] V_BEQ_N  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0001, 1'b0};
    localparam logic [18:0] V_BLTU_T = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0110, 1'b0};
    localparam logic [18:0] V_BR_IL  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'b000, 4'b0000, 1'b1};
    localparam logic [18:0] V_MA_LW  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_MA_SW  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'b001, 4'b0000, 1'b0};
    localparam logic [18:0] V_MEMRD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_MEMWB  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_MEMWR  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_JALR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_JAL    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 3'b000, 4'b0000, 1'b0};
    localparam logic [18:0] V_LUI    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 3'b100, 4'b1111, 1'b0};
    localparam logic [18:0] V_AUIPC  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'b100, 4'b0000, 1'b0};

    // Each scenario task starts in the low phase of a FETCH cycle and ends on
    // the falling edge that opens the next FETCH.

    task automatic test_reset();
        rst   = 1'b0;
        instr = 32'h0000_0013;
        zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (obs !== V_RST) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %05h want %05h", i, obs, V_RST);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== V_FETCH) begin
            miscompares++;
            $display("FAIL reset_release: got %05h want %05h", obs, V_FETCH);
        end
    endtask

    task automatic test_addi();
        logic [18:0] seq[$];
        instr = 32'h0050_0093;
        seq = '{V_FETCH, V_DEC_B, V_EXECI, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL addi cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [18:0] seq[$];
        logic [31:0] ins[2];
        ins[0] = 32'h4020_81B3;  // sub x3,x1,x2
        ins[1] = 32'h4020_D1B3;  // sra x3,x1,x2
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            seq = '{V_FETCH, V_DEC_B, (k == 0) ? V_SUB : V_SRA, V_ALUWB};
            for (int i = 0; i < seq.size(); i++) begin
                #1;
                vectors++;
                if (obs !== seq[i]) begin
                    miscompares++;
                    $display("FAIL rtype%0d cycle %0d: got %05h want %05h", k, i, obs, seq[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch();
        logic [18:0] seq[$];
        logic [31:0] ins[4];
        logic        zf[4];
        logic [18:0] br[4];
        ins[0] = 32'h0020_8463; zf[0] = 1'b1; br[0] = V_BEQ_T;   // beq taken
        ins[1] = 32'h0020_8463; zf[1] = 1'b0; br[1] = V_BEQ_N;   // beq not taken
        ins[2] = 32'h0020_E463; zf[2] = 1'b0; br[2] = V_BLTU_T;  // bltu taken
        ins[3] = 32'h0020_A463; zf[3] = 1'b1; br[3] = V_BR_IL;   // funct3 010
        for (int k = 0; k < 4; k++) begin
            instr = ins[k];
            zero  = zf[k];
            seq = '{V_FETCH, V_DEC_B, br[k]};
            for (int i = 0; i < seq.size(); i++) begin
                #1;
                vectors++;
                if (obs !== seq[i]) begin
                    miscompares++;
                    $display("FAIL branch%0d cycle %0d: got %05h want %05h", k, i, obs, seq[i]);
                end
                @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_load_store();
        logic [18:0] seq[$];
        instr = 32'h0000_A183;  // lw
        seq = '{V_FETCH, V_DEC_B, V_MA_LW, V_MEMRD, V_MEMWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL lw cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
        instr = 32'h0020_A023;  // sw
        seq = '{V_FETCH, V_DEC_B, V_MA_SW, V_MEMWR};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL sw cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jumps();
        logic [18:0] seq[$];
        instr = 32'h0000_80E7;  // jalr x1,0(x1)
        seq = '{V_FETCH, V_DEC_B, V_JALR, V_JAL, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL jalr cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
        instr = 32'h0080_00EF;  // jal x1,8
        seq = '{V_FETCH, V_DEC_J, V_JAL, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL jal cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_upper();
        logic [18:0] seq[$];
        instr = 32'h0000_10B7;  // lui x1,1
        seq = '{V_FETCH, V_DEC_B, V_LUI, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL lui cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
        instr = 32'h0000_1097;  // auipc x1,1
        seq = '{V_FETCH, V_DEC_B, V_AUIPC, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL auipc cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [18:0] seq[$];
        instr = 32'h0000_007F;
        seq = '{V_FETCH, V_DEC_IL, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL illegal cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            if (i < 2) @(negedge clk);
        end
        // The FETCH checked above belongs to the next instruction; finish it.
        instr = 32'h0000_0013;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [18:0] seq[$];
        instr = 32'h0000_A183;  // lw, abandoned in MEMREAD
        seq = '{V_FETCH, V_DEC_B, V_MA_LW, V_MEMRD};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== V_RST) begin
            miscompares++;
            $display("FAIL reset_mid_assert: got %05h want %05h", obs, V_RST);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== V_RST) begin
            miscompares++;
            $display("FAIL reset_mid_hold: got %05h want %05h", obs, V_RST);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== V_FETCH) begin
            miscompares++;
            $display("FAIL reset_mid_release: got %05h want %05h", obs, V_FETCH);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== V_DEC_B) begin
            miscompares++;
            $display("FAIL reset_mid_decode: got %05h want %05h", obs, V_DEC_B);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [18:0] seq[$];
        // Previous lw finishes its MEMADR/MEMREAD/MEMWB above; now a sub
        // immediately followed by a taken beq.
        instr = 32'h4020_81B3;
        seq = '{V_FETCH, V_DEC_B, V_SUB, V_ALUWB};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL b2b_sub cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
        instr = 32'h0020_8463;
        zero  = 1'b1;
        seq = '{V_FETCH, V_DEC_B, V_BEQ_T, V_FETCH};
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            vectors++;
            if (obs !== seq[i]) begin
                miscompares++;
                $display("FAIL b2b_beq cycle %0d: got %05h want %05h", i, obs, seq[i]);
            end
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        instr       = 32'h0000_0013;
        zero        = 1'b0;
        test_reset();
        test_addi();
        test_rtype();
        test_branch();
        test_load_store();
        test_jumps();
        test_upper();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RV32I core. Decodes the instruction held in the datapath's instruction register and sequences the shared datapath (PC, instruction/old-PC/data/A/B/ALUOut registers, ALU, result mux) through fetch, decode, execute, memory and writeback cycles. It sits directly upstream of the datapath: it consumes `instr` and `zero` and drives every select and write enable. Supports lw, sw, R-type, I-type ALU, all six branches, jal, jalr, lui and auipc.

## Interface

Parameters: none.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents
- zero  in  1  ALU zero flag, combinational from the current cycle
- we_pc  out  1  PC register enable
- we_ir  out  1  instruction and old-PC register enable
- we_rf  out  1  register file write enable
- we_mem  out  1  data memory write strobe
- sel_mem_addr  out  1  memory address: 0 = pc, 1 = result
- sel_alu_src_a  out  2  0 = pc, 1 = old_pc, 2 = A (rs1)
- sel_alu_src_b  out  2  0 = B (rs2), 1 = imm_ext, 2 = constant 4
- sel_result  out  2  0 = ALUOut register, 1 = memory data register, 2 = ALU result
- sel_ext  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1111 COPY_B
- illegal  out  1  one-cycle pulse on an unsupported opcode or branch funct3

## Operation

- Default outputs in every state: all enables 0, all selects 0, sel_ext 000, alu_control ADD. Each state lists only its deviations.
- FETCH: sel_mem_addr 0, we_ir 1, src_a 0, src_b 2, sel_result 2, we_pc 1. Next state is DECODE.
- DECODE: src_a 1, src_b 1. sel_ext is J when opcode is 1101111 and B otherwise, so ALUOut receives the jump or branch target. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - Any other opcode: illegal 1, next state FETCH.
- MEMADR: src_a 2, src_b 1, sel_ext I for lw and S for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: sel_mem_addr 1, sel_result 0. Next state is MEMWB.
- MEMWB: sel_result 1, we_rf 1. Next state is FETCH.
- MEMWRITE: sel_mem_addr 1, sel_result 0, we_mem 1. Next state is FETCH.
- EXECR: src_a 2, src_b 0, ALU op from funct3/funct7[5]:
  - 000: ADD, or SUB when funct7[5] = 1
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRL, or SRA when funct7[5] = 1
  - 110 OR, 111 AND
  - Next state is ALUWB.
- EXECI: src_a 2, src_b 1, sel_ext I. Same funct3 decode as EXECR, except 000 is always ADD. Next state is ALUWB.
- ALUWB: sel_result 0, we_rf 1. Next state is FETCH.
- BRANCH: src_a 2, src_b 0, sel_result 0, ALU op and take condition by funct3:
  - beq 000: SUB, taken when zero = 1
  - bne 001: SUB, taken when zero = 0
  - blt 100: SLT, taken when zero = 0
  - bge 101: SLT, taken when zero = 1
  - bltu 110: SLTU, taken when zero = 0
  - bgeu 111: SLTU, taken when zero = 1
  - we_pc = taken. This is the only Mealy output.
  - funct3 010 or 011: not taken, illegal 1.
  - Next state is FETCH.
- JALR: src_a 2, src_b 1, sel_ext I. ALUOut ← rs1+imm; bit 0 of the target is not cleared. Next state is JAL.
- JAL: src_a 1, src_b 2, sel_result 0, we_pc 1. PC ← ALUOut (the target); ALUOut ← old_pc+4. Next state is ALUWB.
- LUI: src_b 1, sel_ext U, alu COPY_B. Next state is ALUWB.
- AUIPC: src_a 1, src_b 1, sel_ext U. Next state is ALUWB.

## Timing

- State register is updated on the rising edge of clk. rst low forces state FETCH immediately, asynchronously.
- While rst is low: we_pc, we_ir, we_rf, we_mem and illegal are forced to 0. All other outputs take FETCH values.
- The first FETCH after reset release occurs on the first rising edge with rst high.
- All outputs are combinational from state and instr (plus zero in BRANCH). There are no output registers.
- Cycles per instruction, FETCH inclusive:
  - branch: 3
  - R-type, I-type, sw, jal, lui, auipc: 4
  - lw, jalr: 5
  - illegal: 2
- rst asserted mid-instruction: the sequence is abandoned and no enable pulses after assertion. Writes already clocked are not undone.

## Test plan

- Reset: hold rst low for 3 cycles with instr = 0x00000013 → all enables 0. After release, FETCH outputs: we_ir=1, we_pc=1, src_b=2, sel_result=2.
- addi x1,x0,5 (0x00500093) → state sequence FETCH, DECODE, EXECI, ALUWB. In EXECI: alu_control 0000, sel_ext 000. In cycle 4: we_rf=1, sel_result 0.
- sub x3,x1,x2 (0x402081B3) → EXECR alu_control 0001. sra (0x4020D1B3) → 1001.
- beq x1,x2 (0x00208463): with zero=1 in cycle 3 → we_pc=1, sel_result 0. With zero=0 → we_pc=0. bltu (0x0020E463) with zero=0 → we_pc=1, alu_control 0110.
- lw (0x0000A183) → 5 cycles; MEMREAD has sel_mem_addr=1; MEMWB has sel_result=1, we_rf=1. sw (0x0020A023) → 4 cycles; MEMADR sel_ext 001; we_mem=1 only in cycle 4.
- jalr (0x000080E7) → states JALR, JAL, ALUWB; we_pc=1 only in FETCH and JAL. Opcode 0x0000007F → illegal=1 in DECODE, next cycle FETCH, no we_rf or we_mem.
